// File: rtl/bounded_counter.sv
// Up/down counter with programmable inclusive bounds, step size and wrap-or-saturate mode.
// Produces a registered boundary-event pulse, a sticky overflow flag and config-error detection.
module bounded_counter #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      STEP_W  = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_n,
    input  logic [WIDTH-1:0]  data_load,
    input  logic              ce,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit_lo,
    input  logic [WIDTH-1:0]  limit_hi,
    input  logic              sat_mode,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  count_out,
    output logic              max_count,
    output logic              min_flag,
    output logic              zero_flag,
    output logic              tc_pulse,
    output logic              ovf_sticky,
    output logic              cfg_err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             evt;

    // One extra bit so neither the sum nor the lower-bound compare can wrap silently.
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] lo_plus;
    logic [WIDTH:0] count_x;
    logic           up_evt;
    logic           dn_evt;
    logic           count_en;

    assign step_x  = (WIDTH + 1)'(step);
    assign count_x = {1'b0, count_q};
    assign up_sum  = count_x + step_x;
    assign lo_plus = {1'b0, limit_lo} + step_x;
    assign up_evt  = up_sum > {1'b0, limit_hi};
    assign dn_evt  = count_x < lo_plus;

    assign cfg_err  = limit_lo > limit_hi;
    assign count_en = ce && !cfg_err && (step != '0);

    always_comb begin
        count_d = count_q;
        evt     = 1'b0;
        if (!load_n) begin
            count_d = data_load;
        end else if (count_en) begin
            if (up_down) begin
                if (up_evt) begin
                    evt     = 1'b1;
                    count_d = sat_mode ? limit_hi : limit_lo;
                end else begin
                    count_d = up_sum[WIDTH-1:0];
                end
            end else begin
                if (dn_evt) begin
                    evt     = 1'b1;
                    count_d = sat_mode ? limit_lo : limit_hi;
                end else begin
                    count_d = count_q - step_x[WIDTH-1:0];
                end
            end
        end
        tc_d  = evt;
        // A fresh event outranks a simultaneous clear.
        ovf_d = evt | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_VAL;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_out  = count_q;
    assign tc_pulse   = tc_q;
    assign ovf_sticky = ovf_q;
    assign max_count  = count_q == limit_hi;
    assign min_flag   = count_q == limit_lo;
    assign zero_flag  = count_q == '0;

endmodule

// File: tb/tb_bounded_counter.sv
// Scoreboard bench for bounded_counter: a driver pushes model predictions per cycle,
// a monitor pops and compares one entry after every rising edge.
module tb_bounded_counter;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_n;
    logic [WIDTH-1:0] data_load;
    logic             ce;
    logic             up_down;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0] limit_lo;
    logic [WIDTH-1:0] limit_hi;
    logic             sat_mode;
    logic             clr_ovf;
    logic [WIDTH-1:0] count_out;
    logic             max_count, min_flag, zero_flag, tc_pulse, ovf_sticky, cfg_err;

    bounded_counter #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W),
        .RST_VAL(8'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_n    (load_n),
        .data_load (data_load),
        .ce        (ce),
        .up_down   (up_down),
        .step      (step),
        .limit_lo  (limit_lo),
        .limit_hi  (limit_hi),
        .sat_mode  (sat_mode),
        .clr_ovf   (clr_ovf),
        .count_out (count_out),
        .max_count (max_count),
        .min_flag  (min_flag),
        .zero_flag (zero_flag),
        .tc_pulse  (tc_pulse),
        .ovf_sticky(ovf_sticky),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit tc;
        bit ovf;
        bit mx;
        bit mn;
        bit z;
        bit err;
        string tag;
    } exp_t;

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string cur_tag  = "init";

    // Behavioural model state
    int m_cnt = 0;
    bit m_tc  = 1'b0;
    bit m_ovf = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s [%s] got=%0d expected=%0d t=%0t", name, cur_tag, got, exp, $time);
    endtask

    // Predict the state after the coming edge from the current inputs, queue it, then
    // advance to the next falling edge where new inputs get applied.
    task automatic tick(input string tag);
        exp_t e;
        int   lo, hi, st;
        bit   evt;
        lo  = int'(limit_lo);
        hi  = int'(limit_hi);
        st  = int'(step);
        evt = 1'b0;
        if (rst) begin
            m_cnt = 0;
            m_tc  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            if (!load_n) begin
                m_cnt = int'(data_load);
            end else if (ce && lo <= hi && st != 0) begin
                if (up_down) begin
                    if (m_cnt + st > hi) begin
                        evt   = 1'b1;
                        m_cnt = sat_mode ? hi : lo;
                    end else begin
                        m_cnt = m_cnt + st;
                    end
                end else begin
                    if (m_cnt - st < lo) begin
                        evt   = 1'b1;
                        m_cnt = sat_mode ? lo : hi;
                    end else begin
                        m_cnt = m_cnt - st;
                    end
                end
            end
            m_tc  = evt;
            m_ovf = evt || (m_ovf && !clr_ovf);
        end
        e.cnt = m_cnt;
        e.tc  = m_tc;
        e.ovf = m_ovf;
        e.mx  = (m_cnt == hi);
        e.mn  = (m_cnt == lo);
        e.z   = (m_cnt == 0);
        e.err = (lo > hi);
        e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a new state after every rising edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e       = sb_q.pop_front();
            cur_tag = e.tag;
            check("count_out",  int'(count_out),  e.cnt);
            check("tc_pulse",   int'(tc_pulse),   int'(e.tc));
            check("ovf_sticky", int'(ovf_sticky), int'(e.ovf));
            check("max_count",  int'(max_count),  int'(e.mx));
            check("min_flag",   int'(min_flag),   int'(e.mn));
            check("zero_flag",  int'(zero_flag),  int'(e.z));
            check("cfg_err",    int'(cfg_err),    int'(e.err));
        end
    end

    task automatic idle_inputs();
        rst       = 1'b0;
        load_n    = 1'b1;
        data_load = '0;
        ce        = 1'b0;
        up_down   = 1'b1;
        step      = '0;
        clr_ovf   = 1'b0;
    endtask

    task automatic load(input int v, input string tag);
        load_n    = 1'b0;
        data_load = WIDTH'(v);
        tick(tag);
        load_n    = 1'b1;
    endtask

    initial begin
        idle_inputs();
        limit_lo = 8'd0;
        limit_hi = 8'd255;
        sat_mode = 1'b0;

        // 1: reset dominates an enabled up count
        rst = 1'b1; ce = 1'b1; step = 4'd1;
        tick("reset");
        tick("reset");
        idle_inputs();

        // 2: wrap up past the upper bound, then a normal step
        limit_lo = 8'd10; limit_hi = 8'd20; step = 4'd3; up_down = 1'b1; sat_mode = 1'b0;
        load(19, "t2_load");
        ce = 1'b1;
        tick("t2_wrap");
        tick("t2_step");
        ce = 1'b0;
        clr_ovf = 1'b1;
        tick("t2_clr");
        clr_ovf = 1'b0;

        // 3: saturating down, repeated event at the bound
        limit_lo = 8'd5; limit_hi = 8'd50; step = 4'd4; up_down = 1'b0; sat_mode = 1'b1;
        load(7, "t3_load");
        ce = 1'b1;
        tick("t3_evt1");
        tick("t3_evt2");
        ce = 1'b0;
        tick("t3_idle");

        // 4: load wins over count; out-of-range value then wraps to lo
        limit_lo = 8'd10; limit_hi = 8'd20; sat_mode = 1'b0; up_down = 1'b1; step = 4'd1;
        ce = 1'b1;
        load(200, "t4_load");
        tick("t4_wrap");
        ce = 1'b0;

        // 5: full-range wrap at 2^WIDTH-1 and sticky clear semantics
        limit_lo = 8'd0; limit_hi = 8'd255; step = 4'd1; up_down = 1'b1; sat_mode = 1'b0;
        load(255, "t5_load");
        ce = 1'b1;
        tick("t5_wrap");
        ce = 1'b0;
        load(255, "t5_reload");
        ce = 1'b1; clr_ovf = 1'b1;
        tick("t5_clr_evt");
        ce = 1'b0;
        tick("t5_clr_only");
        clr_ovf = 1'b0;

        // step=0 holds even outside bounds
        limit_lo = 8'd10; limit_hi = 8'd20;
        load(100, "step0_load");
        ce = 1'b1; step = 4'd0;
        tick("step0_hold");
        ce = 1'b0;

        // lo == hi: any nonzero step is an event
        limit_lo = 8'd42; limit_hi = 8'd42; step = 4'd2; up_down = 1'b0;
        load(42, "eq_load");
        ce = 1'b1;
        tick("eq_evt");
        ce = 1'b0;

        // 6: inverted bounds suppress counting, load still acts
        limit_lo = 8'd30; limit_hi = 8'd20; step = 4'd5; up_down = 1'b1; ce = 1'b1;
        tick("t6_hold");
        tick("t6_hold2");
        load(25, "t6_load");
        ce = 1'b0;

        // Reset mid-operation drops a pending pulse
        limit_lo = 8'd0; limit_hi = 8'd15; step = 4'd8; up_down = 1'b1; ce = 1'b1;
        load(10, "rst_load");
        tick("rst_evt");
        rst = 1'b1; load_n = 1'b0; data_load = 8'd77;
        tick("rst_mid");
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst       = ($urandom_range(0, 99) < 2);
            load_n    = !($urandom_range(0, 99) < 8);
            data_load = WIDTH'($urandom_range(0, 255));
            ce        = ($urandom_range(0, 99) < 85);
            up_down   = 1'($urandom_range(0, 1));
            step      = STEP_W'($urandom_range(0, 15));
            sat_mode  = 1'($urandom_range(0, 1));
            clr_ovf   = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 49) == 0) begin
                r = $urandom_range(0, 3);
                if (r == 0) begin
                    limit_lo = 8'd0; limit_hi = 8'd255;
                end else begin
                    limit_lo = WIDTH'($urandom_range(0, 255));
                    limit_hi = WIDTH'($urandom_range(0, 255));
                    if (r != 3 && limit_lo > limit_hi) begin
                        logic [WIDTH-1:0] t;
                        t = limit_lo; limit_lo = limit_hi; limit_hi = t;
                    end
                end
            end
            tick("random");
        end
        idle_inputs();

        // Let the monitor drain, bounded by a few cycles
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        cur_tag = "drain";
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
